// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan controller: register map,
// CTRL layout, scan-state encoding and the hex-to-segment table.
package seg7_pkg;

  localparam int unsigned ADDR_W = 2;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned SEG_W  = 7;
  localparam int unsigned DIG_W  = 4;
  localparam int unsigned NIB_W  = 4;

  localparam logic [ADDR_W-1:0] ADDR_VALUE  = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_CTRL   = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_FRAMES = 2'd2;

  localparam int unsigned CTRL_EN_BIT   = 0;
  localparam int unsigned CTRL_MASK_LSB = 4;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
  localparam logic [DIG_W-1:0] DIG_OFF   = 4'hF;

  // Architectural CTRL register contents
  typedef struct packed {
    logic [DIG_W-1:0] mask;
    logic             en;
  } ctrl_t;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_t;

  // Active-low gfedcba patterns, entry 15 first down to entry 0
  localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seg7_scan_ctrl_hex_decode.sv
// Hex nibble to active-low seven-segment pattern (purely combinational).
//   nib   : 4-bit hex value
//   seg_c : active-low segments, bit0 = a .. bit6 = g
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [NIB_W-1:0] nib,
  output logic [SEG_W-1:0] seg_c
);

  always_comb begin
    seg_c = SEG_TABLE[nib];
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Memory-mapped 4-digit seven-segment scan controller.
//   clk, reset        : system clock, synchronous active-high reset
//   wr_en/rd_en/addr  : single-cycle register access strobes and address
//   wr_data/rd_data   : write data in, registered read data out
//   seg               : active-low segment cathodes (bit0 = a)
//   digit             : active-low digit anodes (bit0 = rightmost)
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic [SEG_W-1:0]  seg,
  output logic [DIG_W-1:0]  digit
);

  localparam int unsigned CNT_W       = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned SHOW_CYCLES = REFRESH_DIV - BLANK_CYCLES;
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);

  logic [DATA_W-1:0] value_q, value_d;
  ctrl_t             ctrl_q, ctrl_d;
  logic [DATA_W-1:0] frames_q, frames_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  scan_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        idx_q, idx_d;
  logic [DATA_W-1:0] shadow_val_q, shadow_val_d;
  logic [DIG_W-1:0]  shadow_mask_q, shadow_mask_d;
  logic [SEG_W-1:0]  seg_q, seg_d;
  logic [DIG_W-1:0]  digit_q, digit_d;

  logic [DATA_W-1:0] ctrl_rd_c;
  logic [NIB_W-1:0]  cur_nib_c;
  logic [SEG_W-1:0]  dec_seg_c;

  assign rd_data = rd_data_q;
  assign seg     = seg_q;
  assign digit   = digit_q;

  // Bus side: register writes and registered read mux (reads see pre-write values)
  always_comb begin
    value_d   = value_q;
    ctrl_d    = ctrl_q;
    rd_data_d = rd_data_q;
    ctrl_rd_c = {8'h00, ctrl_q.mask, 3'b000, ctrl_q.en};

    if (wr_en) begin
      case (addr)
        ADDR_VALUE: value_d = wr_data;
        ADDR_CTRL: begin
          ctrl_d.en   = wr_data[CTRL_EN_BIT];
          ctrl_d.mask = wr_data[CTRL_MASK_LSB +: DIG_W];
        end
        default: ;
      endcase
    end

    if (rd_en) begin
      case (addr)
        ADDR_VALUE:  rd_data_d = value_q;
        ADDR_CTRL:   rd_data_d = ctrl_rd_c;
        ADDR_FRAMES: rd_data_d = frames_q;
        default:     rd_data_d = '0;
      endcase
    end
  end

  // Scan sequencer; shadows only reload on enable or on the 3->0 wrap
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    shadow_val_d  = shadow_val_q;
    shadow_mask_d = shadow_mask_q;
    frames_d      = frames_q;

    if (!ctrl_q.en) begin
      state_d = ST_OFF;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d       = ST_BLANK;
          cnt_d         = '0;
          idx_d         = '0;
          shadow_val_d  = value_q;
          shadow_mask_d = ctrl_q.mask;
        end
        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            cnt_d   = '0;
            state_d = ST_SHOW;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            cnt_d   = '0;
            idx_d   = idx_q + 2'd1;
            state_d = ST_BLANK;
            if (idx_q == 2'd3) begin
              shadow_val_d  = value_q;
              shadow_mask_d = ctrl_q.mask;
              frames_d      = frames_q + 16'd1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_OFF;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  assign cur_nib_c = shadow_val_q[{idx_q, 2'b00} +: NIB_W];

  seg7_hex_decode u_dec (
    .nib   (cur_nib_c),
    .seg_c (dec_seg_c)
  );

  // Drive pins from the current state; gating on EN blanks the very next edge
  always_comb begin
    seg_d   = SEG_BLANK;
    digit_d = DIG_OFF;
    if (ctrl_q.en && (state_q == ST_SHOW) && shadow_mask_q[idx_q]) begin
      digit_d = ~(DIG_W'(1) << idx_q);
      seg_d   = dec_seg_c;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      value_q       <= '0;
      ctrl_q        <= '0;
      frames_q      <= '0;
      rd_data_q     <= '0;
      state_q       <= ST_BLANK;
      cnt_q         <= '0;
      idx_q         <= '0;
      shadow_val_q  <= '0;
      shadow_mask_q <= '0;
      seg_q         <= SEG_BLANK;
      digit_q       <= DIG_OFF;
    end else begin
      value_q       <= value_d;
      ctrl_q        <= ctrl_d;
      frames_q      <= frames_d;
      rd_data_q     <= rd_data_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shadow_val_q  <= shadow_val_d;
      shadow_mask_q <= shadow_mask_d;
      seg_q         <= seg_d;
      digit_q       <= digit_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with a small slot timing (8 cycles per
// slot, 2 blank). Expected display and read values are queued when stimulus
// is applied and popped as the DUT produces them.
module tb_seg7_scan_ctrl;

  localparam int unsigned RDIV = 8;
  localparam int unsigned BLK  = 2;

  localparam logic [6:0] DEC_TAB [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  localparam logic [3:0] DIG_TAB [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic        rd_en;
  logic [1:0]  addr;
  logic [15:0] wr_data;
  logic [15:0] rd_data;
  logic [6:0]  seg;
  logic [3:0]  digit;

  typedef struct {
    logic [3:0] digit;
    logic [6:0] seg;
    bit         chk_seg;
  } disp_exp_t;

  disp_exp_t   disp_q[$];
  logic [15:0] rd_q[$];
  int          pass_cnt = 0;
  int          fail_cnt = 0;
  int          total_cnt = 0;

  seg7_scan_ctrl #(.REFRESH_DIV(RDIV), .BLANK_CYCLES(BLK)) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .rd_en   (rd_en),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .seg     (seg),
    .digit   (digit)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_blank();
    disp_exp_t e;
    e.digit = 4'hF;
    e.seg = 7'h7F;
    e.chk_seg = 1'b1;
    disp_q.push_back(e);
  endtask

  task automatic push_show(input int idx, input logic [3:0] nib);
    disp_exp_t e;
    e.digit = DIG_TAB[idx];
    e.seg = DEC_TAB[nib];
    e.chk_seg = 1'b1;
    disp_q.push_back(e);
  endtask

  task automatic push_slot(input int idx, input logic [3:0] nib, input logic en);
    disp_exp_t e;
    push_blank();
    push_blank();
    for (int k = 0; k < 6; k++) begin
      if (en) push_show(idx, nib);
      else begin
        e.digit = 4'hF;
        e.seg = 7'h7F;
        e.chk_seg = 1'b0;
        disp_q.push_back(e);
      end
    end
  endtask

  task automatic push_frame(input logic [15:0] value, input logic [3:0] mask);
    for (int i = 0; i < 4; i++) push_slot(i, value[i*4 +: 4], mask[i]);
  endtask

  // Advance one clock and compare the display against the next queued entry
  task automatic step_disp(input string tag);
    disp_exp_t e;
    tick();
    if (disp_q.size() == 0) begin
      total_cnt++;
      fail_cnt++;
      $error("FAIL %s: observed empty queue expected an entry", tag);
    end else begin
      e = disp_q.pop_front();
      check16({tag, "_digit"}, 16'(digit), 16'(e.digit));
      if (e.chk_seg) check16({tag, "_seg"}, 16'(seg), 16'(e.seg));
    end
  endtask

  task automatic run_disp(input string tag, input int n);
    for (int i = 0; i < n; i++) step_disp(tag);
  endtask

  task automatic do_write(input logic [1:0] a, input logic [15:0] d);
    addr = a;
    wr_data = d;
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_read(input logic [1:0] a, input logic [15:0] exp, input string tag);
    addr = a;
    rd_en = 1'b1;
    rd_q.push_back(exp);
    tick();
    rd_en = 1'b0;
    check16(tag, rd_data, rd_q.pop_front());
  endtask

  // Leaves the bench one edge after EN rose: next edge is the first blank output
  task automatic start_scan(input logic [15:0] v, input logic [15:0] c);
    do_write(2'd1, 16'h0000);
    do_write(2'd0, v);
    do_write(2'd1, c);
    tick();
  endtask

  initial begin
    reset = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    addr = 2'd0;
    wr_data = 16'h0000;
    repeat (5) tick();
    check16("rst_seg", 16'(seg), 16'h007F);
    check16("rst_digit", 16'(digit), 16'h000F);
    check16("rst_rd_data", rd_data, 16'h0000);
    reset = 1'b0;
    do_read(2'd0, 16'h0000, "rst_value");
    do_read(2'd1, 16'h0000, "rst_ctrl");
    do_read(2'd2, 16'h0000, "rst_frames");

    // Basic scan of 1234 on all digits
    start_scan(16'h1234, 16'h00F1);
    push_frame(16'h1234, 4'hF);
    run_disp("basic", 32);
    do_read(2'd2, 16'd1, "frames_basic");

    // Only digits 0 and 2 enabled
    start_scan(16'hABCD, 16'h0051);
    push_frame(16'hABCD, 4'h5);
    run_disp("mask", 32);

    // VALUE rewritten mid-frame: current frame keeps old nibbles
    start_scan(16'h1234, 16'h00F1);
    push_frame(16'h1234, 4'hF);
    run_disp("tear_old", 11);
    addr = 2'd0;
    wr_data = 16'hFFFF;
    wr_en = 1'b1;
    step_disp("tear_wr");
    wr_en = 1'b0;
    run_disp("tear_old", 20);
    push_frame(16'hFFFF, 4'hF);
    run_disp("tear_new", 32);

    // Disable during SHOW of digit 0, then re-enable with a new value
    push_blank();
    push_blank();
    push_show(0, 4'hF);
    push_show(0, 4'hF);
    run_disp("dis_pre", 4);
    addr = 2'd1;
    wr_data = 16'h00F0;
    wr_en = 1'b1;
    push_show(0, 4'hF);
    step_disp("dis_wr");
    wr_en = 1'b0;
    push_blank();
    push_blank();
    push_blank();
    run_disp("dis_off", 3);
    do_write(2'd0, 16'h5678);
    addr = 2'd1;
    wr_data = 16'h00F1;
    wr_en = 1'b1;
    push_blank();
    step_disp("reen_wr");
    wr_en = 1'b0;
    push_blank();
    step_disp("reen_off");
    push_frame(16'h5678, 4'hF);
    run_disp("reen", 32);
    do_read(2'd2, 16'd5, "frames_reen");

    // Bus corner cases
    do_write(2'd1, 16'h0000);
    addr = 2'd0;
    wr_data = 16'h9999;
    wr_en = 1'b1;
    rd_en = 1'b1;
    rd_q.push_back(16'h5678);
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    check16("rdwr_same", rd_data, rd_q.pop_front());
    do_read(2'd0, 16'h9999, "value_new");
    do_write(2'd2, 16'h1234);
    do_read(2'd2, 16'd5, "frames_ro");
    do_write(2'd3, 16'hBEEF);
    do_read(2'd3, 16'h0000, "addr3");
    do_write(2'd1, 16'hFFFF);
    do_read(2'd1, 16'h00F1, "ctrl_bits");
    repeat (2) tick();
    check16("rd_hold", rd_data, 16'h00F1);
    do_write(2'd1, 16'h0000);

    // Reset while a digit is lit
    start_scan(16'h1234, 16'h00F1);
    push_blank();
    push_blank();
    push_show(0, 4'h4);
    run_disp("pre_rst", 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check16("mid_rst_seg", 16'(seg), 16'h007F);
    check16("mid_rst_digit", 16'(digit), 16'h000F);
    check16("mid_rst_rd", rd_data, 16'h0000);
    push_blank();
    push_blank();
    run_disp("post_rst", 2);
    do_read(2'd0, 16'h0000, "mid_rst_value");
    do_read(2'd1, 16'h0000, "mid_rst_ctrl");
    do_read(2'd2, 16'h0000, "mid_rst_frames");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Memory-mapped controller that time-multiplexes the HolySoC 4-digit seven-segment display (`seg[6:0]`, `digit[3:0]`) from CPU-written registers.
- Sequences digit scanning with a blanking interval per digit to suppress ghosting.
- Latches display values only at frame boundaries so the display never tears.
- Sits on the SoC peripheral bus beside the LED/switch/button I/O; its outputs drive the top-level `seg`/`digit` pins directly.

Parameters:
- REFRESH_DIV, 100000, clk cycles per digit slot (1 kHz slot rate at 100 MHz); must be >= 2.
- BLANK_CYCLES, 1000, cycles at slot start with all digits off; must satisfy 1 <= BLANK_CYCLES < REFRESH_DIV.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- wr_en  input  1  register write strobe, single-cycle
- rd_en  input  1  register read strobe, single-cycle
- addr  input  2  register address
- wr_data  input  16  write data
- rd_data  output  16  read data, valid the cycle after rd_en
- seg  output  7  segment cathodes, active-low, `seg[0]`=a .. `seg[6]`=g
- digit  output  4  digit anodes, active-low, `digit[0]` = rightmost digit

Behaviour:
- Register map:
  - addr 0, VALUE: 4 hex nibbles; nibble i shows on digit i.
  - addr 1, CTRL: bit0 EN; bits[7:4] MASK, where a 1 enables digit i; other bits read 0.
  - addr 2, FRAMES: read-only 16-bit frame counter; writes are ignored.
  - addr 3: reads 0, writes ignored.
- Reset values:
  - VALUE=0, CTRL=0, FRAMES=0, rd_data=0.
  - seg=7'h7F, digit=4'hF.
  - Slot counter=0, digit index=0, state=BLANK, shadow VALUE/MASK=0.
- Writes take effect in the architectural register on the next clk edge.
- rd_data is registered:
  - Returns the architectural register one cycle after rd_en.
  - Holds its value when rd_en=0.
  - On a read and write to the same addr in the same cycle, rd_data returns the old value.
- Shadowing: VALUE and MASK copy into shadow registers only when the digit index wraps 3->0, or at the first slot after EN rises. The display always uses the shadows.
- Scan FSM, states OFF, BLANK, SHOW:
  - OFF: digit=4'hF, seg=7'h7F, counters held at 0. When EN=1, go to BLANK with index 0, loading shadows that cycle.
  - BLANK: lasts BLANK_CYCLES cycles; digit=4'hF, seg=7'h7F. Then go to SHOW.
  - SHOW: lasts REFRESH_DIV-BLANK_CYCLES cycles.
    - If shadow MASK[idx]=1: `digit[idx]`=0 and seg = decode(shadow nibble idx). Otherwise digit=4'hF.
    - At the end of SHOW: idx <= idx+1 (mod 4) and go to BLANK.
    - On wrap 3->0: reload shadows and FRAMES <= FRAMES+1, wrapping 16'hFFFF->0.
- EN cleared at any time: next state is OFF. Outputs blank on the following edge and any partial slot is abandoned.
- Outputs seg and digit are registered with no combinational path from the bus. A decode change appears 1 cycle after the state/idx change.
- Decode table, active-low gfedcba:
  - 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78
  - 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E
- Reset asserted mid-scan: all state returns to the reset values on that edge, regardless of FSM state.

Decomposition:
- Package seg7_pkg holds:
  - Register address constants (ADDR_VALUE=0, ADDR_CTRL=1, ADDR_FRAMES=2).
  - CTRL bit positions.
  - Scan-state encoding (OFF, BLANK, SHOW).
  - The hex-to-segment constant table.
- Sub-module seg7_hex_decode: purely combinational, 4-bit nibble in, 7-bit active-low segments out. Instantiated once and fed by the muxed shadow nibble.

Test Plan (REFRESH_DIV=8, BLANK_CYCLES=2):
- Reset check: reset held 5 cycles -> seg=7F, digit=F, reads of addr 0/1/2 return 0000.
- Basic scan: write VALUE=16'h1234, CTRL=16'h00F1 -> expect the following per slot, and FRAMES=1 after 32 cycles:
  - digit=F for 2 cycles, then digit=E/seg=19 (4) for 6 cycles.
  - Then digit=D/seg=30, then digit=B/seg=24, then digit=7/seg=79.
- Masking: CTRL=16'h0051 with VALUE=16'hABCD -> only digit0 (seg=21) and digit2 (seg=03) ever go low; the slots for digits 1 and 3 stay digit=F.
- Tear-free update: write VALUE=16'hFFFF during the SHOW slot of digit 1 -> digits 2 and 3 still show the old nibbles; the new value (seg=0E) appears only from the next digit-0 slot.
- Disable mid-slot: clear EN during SHOW -> digit=F and seg=7F on the next edge. Re-enabling starts at BLANK with idx 0.
- Bus corner: read and write addr 0 in the same cycle -> rd_data shows the old value; a write to addr 2 leaves FRAMES unchanged; a read of addr 3 returns 0000.
